clock_multimode: RTL and testbench

CLOCK_MULTIMODE -- requirements
Module: clock_multimode

---
 rtl/clock_multimode.sv | 133 +++++++++++++
 tb/tb_clock_multimode.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_multimode.sv
// Time-of-day clock with a 12 h / 24 h display mode, a validated time load
// and a minute-resolution alarm. Time is kept internally as a 24 h count;
// the 12 h view and the AM/PM flag are derived combinationally.
module clock_multimode #(
  parameter int TICKS_PER_SEC  = 100000000,
  parameter bit MODE24_DEFAULT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_set,
  input  logic       mode24_in,
  input  logic       load,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_mins,
  input  logic [5:0] load_secs,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_mins,
  output logic [4:0] hours,
  output logic [5:0] mins,
  output logic [5:0] secs,
  output logic       A_P,
  output logic       mode24,
  output logic       sec_pulse,
  output logic       alarm,
  output logic       load_err
);

  localparam logic [30:0] PRESC_LAST = 31'(TICKS_PER_SEC - 1);

  logic [30:0] presc;
  logic [4:0]  h, h_inc;
  logic [5:0]  m, m_inc;
  logic [5:0]  s, s_inc;
  logic        tick;
  logic        load_ok;
  logic        load_bad;
  logic        alarm_hit;

  assign tick     = (presc == PRESC_LAST);
  assign load_ok  = load && (load_hours <= 5'd23) && (load_mins <= 6'd59) && (load_secs <= 6'd59);
  assign load_bad = load && !load_ok;

  // Time one second later, with carries and 24 h wrap; never produces 60 or 24.
  always_comb begin
    s_inc = s;
    m_inc = m;
    h_inc = h;
    if (s == 6'd59) begin
      s_inc = 6'd0;
      if (m == 6'd59) begin
        m_inc = 6'd0;
        h_inc = (h == 5'd23) ? 5'd0 : h + 5'd1;
      end else begin
        m_inc = m + 6'd1;
      end
    end else begin
      s_inc = s + 6'd1;
    end
  end

  // Alarm only matches on a tick-driven advance; a load on the same edge wins and suppresses it.
  // Out-of-range alarm fields can never equal an in-range counter value.
  assign alarm_hit = alarm_en && tick && !load_ok &&
                     (h_inc == alarm_hours) && (m_inc == alarm_mins) && (s_inc == 6'd0);

  // Prescaler: wraps on the tick, restarts on a valid load so the next second is a full one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (load_ok || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 31'd1;
    end
  end

  // Time registers: a valid load takes priority over a coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= '0;
      m <= '0;
      s <= '0;
    end else if (load_ok) begin
      h <= load_hours;
      m <= load_mins;
      s <= load_secs;
    end else if (tick) begin
      h <= h_inc;
      m <= m_inc;
      s <= s_inc;
    end
  end

  // Display mode register, independent of the time path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode24 <= MODE24_DEFAULT;
    end else if (mode_set) begin
      mode24 <= mode24_in;
    end
  end

  // Registered one-cycle event pulses, visible in the cycle after the causing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_pulse <= 1'b0;
      alarm     <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_pulse <= tick && !load_ok;
      alarm     <= alarm_hit;
      load_err  <= load_bad;
    end
  end

  // Display mapping: 0 shows as 12 AM, 13-23 fold down to 1-11 PM in 12 h mode.
  always_comb begin
    A_P  = (h >= 5'd12);
    mins = m;
    secs = s;
    if (mode24) begin
      hours = h;
    end else if (h == 5'd0) begin
      hours = 5'd12;
    end else if (h > 5'd12) begin
      hours = h - 5'd12;
    end else begin
      hours = h;
    end
  end

endmodule

// File: tb/tb_clock_multimode.sv
// Bench for clock_multimode with a 4-cycle second. Expected displayed time at
// each sec_pulse is queued by the scenario tasks and checked by a monitor.
module tb_clock_multimode;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_set;
  logic       mode24_in;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_mins;
  logic [5:0] load_secs;
  logic       alarm_en;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_mins;
  logic [4:0] hours;
  logic [5:0] mins;
  logic [5:0] secs;
  logic       A_P;
  logic       mode24;
  logic       sec_pulse;
  logic       alarm;
  logic       load_err;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       ap;
  } disp_t;

  disp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  clock_multimode #(.TICKS_PER_SEC(4), .MODE24_DEFAULT(1'b0)) dut (
    .clk(clk), .reset(reset), .mode_set(mode_set), .mode24_in(mode24_in),
    .load(load), .load_hours(load_hours), .load_mins(load_mins), .load_secs(load_secs),
    .alarm_en(alarm_en), .alarm_hours(alarm_hours), .alarm_mins(alarm_mins),
    .hours(hours), .mins(mins), .secs(secs), .A_P(A_P), .mode24(mode24),
    .sec_pulse(sec_pulse), .alarm(alarm), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic disp_t mk(input logic [4:0] h, input logic [5:0] m,
                               input logic [5:0] s, input logic ap);
    disp_t d;
    d.h = h; d.m = m; d.s = s; d.ap = ap;
    return d;
  endfunction

  // Scoreboard: every sec_pulse must match the next queued expected display.
  always @(posedge clk) begin
    disp_t e;
    #2;
    if (sec_pulse === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_pulse got %0d:%0d:%0d ap=%0d want no pulse", hours, mins, secs, A_P);
      end else begin
        e = exp_q.pop_front();
        if ({hours, mins, secs, A_P} !== e) begin
          errors++;
          $display("FAIL sb_pulse_time got %0d:%0d:%0d ap=%0d want %0d:%0d:%0d ap=%0d",
                   hours, mins, secs, A_P, e.h, e.m, e.s, e.ap);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    load = 1'b1; load_hours = h; load_mins = m; load_secs = s;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    int pulse_cnt;
    bit spacing_ok;
    reset = 1'b1; mode_set = 1'b0; mode24_in = 1'b0; load = 1'b0;
    load_hours = '0; load_mins = '0; load_secs = '0;
    alarm_en = 1'b0; alarm_hours = '0; alarm_mins = '0;
    repeat (3) step();
    checks++;
    if ({hours, mins, secs, A_P} !== mk(5'd12, 6'd0, 6'd0, 1'b0)) begin
      errors++;
      $display("FAIL reset_display got %0d:%0d:%0d ap=%0d want 12:0:0 ap=0", hours, mins, secs, A_P);
    end
    checks++;
    if ({mode24, sec_pulse, alarm, load_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {mode24, sec_pulse, alarm, load_err});
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(mk(5'd12, 6'd0, 6'(i), 1'b0));
    pulse_cnt = 0;
    spacing_ok = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (sec_pulse === 1'b1) begin
        pulse_cnt++;
        if (c != 4 * pulse_cnt) spacing_ok = 1'b0;
      end
    end
    checks++;
    if (pulse_cnt != 4) begin
      errors++;
      $display("FAIL run16_pulse_count got %0d want 4", pulse_cnt);
    end
    checks++;
    if (!spacing_ok) begin
      errors++;
      $display("FAIL run16_pulse_spacing got irregular want every 4 cycles");
    end
    checks++;
    if ({hours, mins, secs, A_P} !== mk(5'd12, 6'd0, 6'd4, 1'b0)) begin
      errors++;
      $display("FAIL run16_display got %0d:%0d:%0d ap=%0d want 12:0:4 ap=0", hours, mins, secs, A_P);
    end
  endtask

  task automatic test_wrap();
    do_load(5'd23, 6'd59, 6'd59);
    checks++;
    if ({hours, mins, secs, A_P} !== mk(5'd11, 6'd59, 6'd59, 1'b1)) begin
      errors++;
      $display("FAIL wrap_before got %0d:%0d:%0d ap=%0d want 11:59:59 ap=1", hours, mins, secs, A_P);
    end
    exp_q.push_back(mk(5'd12, 6'd0, 6'd0, 1'b0));
    repeat (4) step();
    checks++;
    if ({hours, mins, secs, A_P, sec_pulse} !== {mk(5'd12, 6'd0, 6'd0, 1'b0), 1'b1}) begin
      errors++;
      $display("FAIL wrap_after got %0d:%0d:%0d ap=%0d pulse=%0d want 12:0:0 ap=0 pulse=1",
               hours, mins, secs, A_P, sec_pulse);
    end
  endtask

  task automatic test_mode();
    do_load(5'd12, 6'd0, 6'd0);
    checks++;
    if ({mode24, hours, A_P} !== {1'b0, 5'd12, 1'b1}) begin
      errors++;
      $display("FAIL mode_noon12 got m24=%0d h=%0d ap=%0d want 0 12 1", mode24, hours, A_P);
    end
    mode_set = 1'b1; mode24_in = 1'b1;
    step();
    checks++;
    if ({mode24, hours, A_P} !== {1'b1, 5'd12, 1'b1}) begin
      errors++;
      $display("FAIL mode_noon24 got m24=%0d h=%0d ap=%0d want 1 12 1", mode24, hours, A_P);
    end
    mode24_in = 1'b0;
    step();
    mode_set = 1'b0;
    checks++;
    if ({mode24, hours, A_P} !== {1'b0, 5'd12, 1'b1}) begin
      errors++;
      $display("FAIL mode_noon_back12 got m24=%0d h=%0d ap=%0d want 0 12 1", mode24, hours, A_P);
    end
    do_load(5'd13, 6'd0, 6'd0);
    checks++;
    if ({hours, A_P} !== {5'd1, 1'b1}) begin
      errors++;
      $display("FAIL mode_13_in12 got h=%0d ap=%0d want 1 1", hours, A_P);
    end
    mode_set = 1'b1; mode24_in = 1'b1;
    do_load(5'd13, 6'd0, 6'd5);
    mode_set = 1'b0;
    checks++;
    if ({mode24, hours, secs, A_P} !== {1'b1, 5'd13, 6'd5, 1'b1}) begin
      errors++;
      $display("FAIL mode_load_same_cycle got m24=%0d h=%0d s=%0d ap=%0d want 1 13 5 1",
               mode24, hours, secs, A_P);
    end
    mode_set = 1'b1; mode24_in = 1'b0;
    step();
    mode_set = 1'b0;
    checks++;
    if ({mode24, hours} !== {1'b0, 5'd1}) begin
      errors++;
      $display("FAIL mode_restore12 got m24=%0d h=%0d want 0 1", mode24, hours);
    end
  endtask

  task automatic test_load_err();
    do_load(5'd5, 6'd60, 6'd0);
    checks++;
    if ({load_err, hours, mins, secs} !== {1'b1, 5'd1, 6'd0, 6'd5}) begin
      errors++;
      $display("FAIL err_mins60 got err=%0d %0d:%0d:%0d want err=1 1:0:5", load_err, hours, mins, secs);
    end
    step();
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle got %0d want 0", load_err);
    end
    exp_q.push_back(mk(5'd1, 6'd0, 6'd6, 1'b1));
    step();
    checks++;
    if ({secs, sec_pulse} !== {6'd6, 1'b1}) begin
      errors++;
      $display("FAIL err_keeps_counting got s=%0d pulse=%0d want 6 1", secs, sec_pulse);
    end
    do_load(5'd24, 6'd0, 6'd0);
    checks++;
    if ({load_err, hours, secs} !== {1'b1, 5'd1, 6'd6}) begin
      errors++;
      $display("FAIL err_hours24 got err=%0d h=%0d s=%0d want 1 1 6", load_err, hours, secs);
    end
    exp_q.push_back(mk(5'd1, 6'd0, 6'd7, 1'b1));
    repeat (3) step();
  endtask

  task automatic test_alarm();
    int cnt;
    int at;
    alarm_hours = 5'd7; alarm_mins = 6'd30; alarm_en = 1'b1;
    do_load(5'd7, 6'd29, 6'd59);
    exp_q.push_back(mk(5'd7, 6'd30, 6'd0, 1'b0));
    cnt = 0; at = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (alarm === 1'b1) begin cnt++; at = c; end
    end
    checks++;
    if (cnt != 1 || at != 4) begin
      errors++;
      $display("FAIL alarm_tick got count=%0d cycle=%0d want count=1 cycle=4", cnt, at);
    end
    do_load(5'd7, 6'd30, 6'd0);
    cnt = (alarm === 1'b1) ? 1 : 0;
    exp_q.push_back(mk(5'd7, 6'd30, 6'd1, 1'b0));
    exp_q.push_back(mk(5'd7, 6'd30, 6'd2, 1'b0));
    for (int c = 1; c <= 8; c++) begin
      step();
      if (alarm === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL alarm_via_load got count=%0d want 0", cnt);
    end
    alarm_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int first;
    repeat (3) step();
    do_load(5'd10, 6'd20, 6'd30);
    checks++;
    if ({hours, mins, secs, sec_pulse} !== {5'd10, 6'd20, 6'd30, 1'b0}) begin
      errors++;
      $display("FAIL load_on_tick got %0d:%0d:%0d pulse=%0d want 10:20:30 pulse=0",
               hours, mins, secs, sec_pulse);
    end
    exp_q.push_back(mk(5'd10, 6'd20, 6'd31, 1'b0));
    first = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (sec_pulse === 1'b1 && first == 0) first = c;
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL load_on_tick_next_pulse got cycle %0d want 4", first);
    end
    mode_set = 1'b1; mode24_in = 1'b1;
    step();
    mode_set = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mode24, hours, mins, secs, A_P, sec_pulse, alarm, load_err} !==
        {1'b0, 5'd12, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midsec_reset got m24=%0d %0d:%0d:%0d ap=%0d pulses=%b want 0 12:0:0 ap=0 pulses=000",
               mode24, hours, mins, secs, A_P, {sec_pulse, alarm, load_err});
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(mk(5'd12, 6'd0, 6'd1, 1'b0));
    first = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (sec_pulse === 1'b1 && first == 0) first = c;
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL post_reset_first_pulse got cycle %0d want 4", first);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_mode();
    test_load_err();
    test_alarm();
    test_back_to_back();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
